uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised UART transmitter with a small input FIFO, the next-generation replacement for the fixed 8N1 transmitter in the FIR filter output path. It serialises words written by the filter/control logic onto a single TX line at a compile-time baud rate. Data width, parity mode, stop-bit count and FIFO depth are configurable. Frames are sent back-to-back with no idle gap while the FIFO holds data.

## Interface
- CLK_FREQ, 50_000_000, clock frequency in Hz
- BAUD, 115200, line rate in bit/s
- DATA_BITS, 8, payload bits per frame, legal 5..9
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, legal 1 or 2
- FIFO_DEPTH, 4, power of two, ≥ 2
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  write strobe; word accepted on a rising edge where start=1 and full=0
- data  input  DATA_BITS  word to transmit, sampled with start
- full  output  1  FIFO full; writes are dropped while high
- out  output  1  serial TX line, idles high, registered
- busy  output  1  high while a frame is in flight or the FIFO is non-empty

## Operation
- DIV = (CLK_FREQ + BAUD/2) / BAUD, computed at elaboration. Every line bit lasts exactly DIV clocks.
- Frame format: start bit (0), then DATA_BITS data bits LSB first, then an optional parity bit, then STOP_BITS stop bits (1).
- Parity bit: even = XOR of data bits; odd = XNOR of data bits.
- FIFO: circular buffer with a log2(FIFO_DEPTH)+1-bit count. Pointers wrap modulo FIFO_DEPTH.
- A write while full=1 is dropped, including when a pop happens in the same cycle. A write and a pop in the same cycle leave the count unchanged.
- FSM states:
  - IDLE: out=1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: out=0 for DIV clocks, then go to DATA.
  - DATA: shift out DATA_BITS bits. Then go to PARITY if PARITY≠0, otherwise go to STOP.
  - PARITY: one bit time, then go to STOP.
  - STOP: out=1 for STOP_BITS×DIV clocks. On the last clock, if the FIFO is non-empty, pop and go directly to START; otherwise go to IDLE.
- Counters: a baud counter runs 0..DIV-1; a bit index runs 0..DATA_BITS-1; a stop counter counts stop bits.
- busy = (state≠IDLE) | (count≠0). full = (count==FIFO_DEPTH).
- Reset values: out=1, busy=0, full=0, FIFO empty, state=IDLE, all counters 0.
- Reset asserted mid-frame: out goes to 1 immediately (asynchronously), the frame is abandoned and FIFO contents are discarded. Nothing is transmitted after release until a new write.

## Timing
- Write sampled at edge k. If the block is idle, the pop happens at edge k+1 and out falls after edge k+2. Start-bit latency from the write edge is 2 clocks.
- Frame length: (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × DIV clocks.
- Back-to-back frames: the next start bit begins on the clock after the last stop-bit clock, so the line has zero idle gap.
- full updates on the edge after the write that fills the FIFO; a write in that same cycle is still accepted only if full was 0 at the edge.
- Holding start high continuously writes the same data every cycle until full.

## Test plan
Test parameters for all scenarios: CLK_FREQ=1_000_000, BAUD=100_000 (DIV=10).
- 8N1, write 0x4C once -> out = 0, 0,0,1,1,0,0,1,0, 1; each bit exactly 10 clocks. busy drops exactly 100 clocks after out first falls.
- PARITY=2, write 0x4C -> parity bit 1, frame 110 clocks. PARITY=1 -> parity bit 0.
- FIFO_DEPTH=4, writes A..F on 6 consecutive clocks from idle -> full rises after E and F is dropped. A..E go out as 5 contiguous frames (500 clocks, out never idles high between stop and start bits), then busy=0.
- DATA_BITS=7, STOP_BITS=2, write 0x55 -> 7 data bits 1,0,1,0,1,0,1 followed by 20 clocks high; total 100 clocks.
- Reset pulse during bit 3 of a frame with 2 words queued -> out=1 and busy=0 during reset. full=0. No activity on out for 200 clocks after release.
- Start held high for 3 clocks, then released -> 3 identical frames (the first popped word plus 2 queued), no dropped write, full never asserted.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small write FIFO. Frame: start bit, DATA_BITS data
// bits LSB first, optional parity bit, STOP_BITS stop bits. Frames are sent
// back-to-back with no idle gap while the FIFO holds data.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | line high, waiting for the FIFO to become non-empty
// S_START  | start bit (0) for DIV clocks
// S_DATA   | DATA_BITS payload bits, LSB first, DIV clocks each
// S_PARITY | parity bit for DIV clocks (only when PARITY != 0)
// S_STOP   | STOP_BITS stop bits; last clock pops the next word if any
module uart_tx_fifo #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [DATA_BITS-1:0] data,
   output logic                 full,
   output logic                 out,
   output logic                 busy
);

   localparam int DIV    = (CLK_FREQ + BAUD / 2) / BAUD;
   localparam int BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BIT_W  = $clog2(DATA_BITS);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
   localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t                state_q;
   logic [BAUD_W-1:0]     baud_q;
   logic [BIT_W-1:0]      bit_q;
   logic                  stop_q;
   logic [DATA_BITS-1:0]  shift_q;
   logic                  par_q;
   logic                  out_q;
   logic                  busy_q;

   logic [DATA_BITS-1:0]  mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q;
   logic [PTR_W-1:0]      rd_ptr_q;
   logic [CNT_W-1:0]      count_q;
   logic [CNT_W-1:0]      count_d;

   logic                  push;
   logic                  pop;
   logic                  fifo_empty;
   logic                  baud_last;
   logic                  frame_end;
   logic                  par_bit;
   logic                  line_d;

   assign fifo_empty = (count_q == '0);
   assign full       = (count_q == CNT_FULL);
   assign push       = start & ~full;
   assign baud_last  = (baud_q == BAUD_LAST);
   assign frame_end  = (state_q == S_STOP) && baud_last && (stop_q == STOP_LAST);
   assign pop        = ~fifo_empty && ((state_q == S_IDLE) || frame_end);

   // odd parity is the complement of the XOR taken at pop time
   assign par_bit = (PARITY == 1) ? ~par_q : par_q;

   // line level for the current state; registered into out_q one clock later
   always_comb begin
      line_d = 1'b1;
      case (state_q)
         S_START:  line_d = 1'b0;
         S_DATA:   line_d = shift_q[0];
         S_PARITY: line_d = par_bit;
         default:  line_d = 1'b1;
      endcase
   end

   // occupancy: a simultaneous push and pop leaves the count unchanged
   always_comb begin
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   // FIFO storage, no reset needed since the count gates every read
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= data;
   end

   // FIFO pointers and count; power-of-two depth lets the pointers wrap freely
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   // frame sequencer with registered line and busy outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         stop_q  <= 1'b0;
         shift_q <= '0;
         par_q   <= 1'b0;
         out_q   <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         out_q  <= line_d;
         busy_q <= (state_q != S_IDLE) | ~fifo_empty;
         case (state_q)
            S_IDLE: begin
               if (pop) begin
                  shift_q <= mem_q[rd_ptr_q];
                  par_q   <= ^mem_q[rd_ptr_q];
                  baud_q  <= '0;
                  state_q <= S_START;
               end
            end
            S_START: begin
               if (baud_last) begin
                  baud_q  <= '0;
                  bit_q   <= '0;
                  state_q <= S_DATA;
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            S_DATA: begin
               if (baud_last) begin
                  baud_q  <= '0;
                  shift_q <= shift_q >> 1;
                  if (bit_q == BIT_LAST) begin
                     stop_q  <= 1'b0;
                     state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
                  end else begin
                     bit_q <= bit_q + 1'b1;
                  end
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            S_PARITY: begin
               if (baud_last) begin
                  baud_q  <= '0;
                  stop_q  <= 1'b0;
                  state_q <= S_STOP;
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            S_STOP: begin
               if (baud_last) begin
                  baud_q <= '0;
                  if (stop_q == STOP_LAST) begin
                     stop_q <= 1'b0;
                     if (pop) begin
                        shift_q <= mem_q[rd_ptr_q];
                        par_q   <= ^mem_q[rd_ptr_q];
                        state_q <= S_START;
                     end else begin
                        state_q <= S_IDLE;
                     end
                  end else begin
                     stop_q <= stop_q + 1'b1;
                  end
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign out  = out_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at DIV=10 with four parameter sets:
// 8N1 depth 4, 8E1, 8O1 and 7N2.
module tb_uart_tx_fifo;

   localparam int W = 640;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic       st_n, st_e, st_o, st_7;
   logic [7:0] d_n, d_e, d_o;
   logic [6:0] d_7;
   logic       full_n, out_n, busy_n;
   logic       full_e, out_e, busy_e;
   logic       full_o, out_o, busy_o;
   logic       full_7, out_7, busy_7;

   int checks = 0;
   int errors = 0;

   logic [7:0] words [6];

   uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_n (
      .clk(clk), .rst_n(rst_n), .start(st_n), .data(d_n),
      .full(full_n), .out(out_n), .busy(busy_n));

   uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_e (
      .clk(clk), .rst_n(rst_n), .start(st_e), .data(d_e),
      .full(full_e), .out(out_e), .busy(busy_e));

   uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(1),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_o (
      .clk(clk), .rst_n(rst_n), .start(st_o), .data(d_o),
      .full(full_o), .out(out_o), .busy(busy_o));

   uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(0),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) u_7 (
      .clk(clk), .rst_n(rst_n), .start(st_7), .data(d_7),
      .full(full_7), .out(out_7), .busy(busy_7));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] ones(input int n);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < n; i++) r[i] = 1'b1;
      return r;
   endfunction

   task automatic add_bit(inout logic [W-1:0] w, inout int pos, input logic b);
      for (int i = 0; i < 10; i++) begin
         w[pos] = b;
         pos++;
      end
   endtask

   // expected line waveform for one frame, 10 samples per bit
   task automatic add_frame(inout logic [W-1:0] w, inout int pos, input logic [8:0] word,
                            input int nb, input int par, input int ns);
      logic p;
      p = 1'b0;
      add_bit(w, pos, 1'b0);
      for (int i = 0; i < nb; i++) begin
         add_bit(w, pos, word[i]);
         p = p ^ word[i];
      end
      if (par == 1) add_bit(w, pos, ~p);
      if (par == 2) add_bit(w, pos, p);
      for (int i = 0; i < ns; i++) add_bit(w, pos, 1'b1);
   endtask

   // sample out/busy/full once per falling edge for n clocks
   task automatic cap(input int sel, input int n, output logic [W-1:0] wo,
                      output logic [W-1:0] wb, output logic [W-1:0] wf);
      wo = '0;
      wb = '0;
      wf = '0;
      for (int i = 0; i < n; i++) begin
         case (sel)
            0: begin wo[i] = out_n; wb[i] = busy_n; wf[i] = full_n; end
            1: begin wo[i] = out_e; wb[i] = busy_e; wf[i] = full_e; end
            2: begin wo[i] = out_o; wb[i] = busy_o; wf[i] = full_o; end
            default: begin wo[i] = out_7; wb[i] = busy_7; wf[i] = full_7; end
         endcase
         @(negedge clk);
      end
   endtask

   initial begin
      logic [W-1:0] wo, wb, wf, e;
      int pos;

      words = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
      rst_n = 1'b0;
      st_n = 1'b0; st_e = 1'b0; st_o = 1'b0; st_7 = 1'b0;
      d_n = '0; d_e = '0; d_o = '0; d_7 = '0;
      repeat (3) @(negedge clk);

      chk("rst_out_n", out_n, 1);  chk("rst_busy_n", busy_n, 0);  chk("rst_full_n", full_n, 0);
      chk("rst_out_e", out_e, 1);  chk("rst_busy_e", busy_e, 0);  chk("rst_full_e", full_e, 0);
      chk("rst_out_o", out_o, 1);  chk("rst_busy_o", busy_o, 0);  chk("rst_full_o", full_o, 0);
      chk("rst_out_7", out_7, 1);  chk("rst_busy_7", busy_7, 0);  chk("rst_full_7", full_7, 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // 8N1, single word 0x4C, start-bit latency 2 clocks
      d_n = 8'h4C; st_n = 1'b1;
      @(negedge clk); st_n = 1'b0;
      chk("t1_lat1", out_n, 1);
      @(negedge clk);
      chk("t1_lat2", out_n, 1);
      @(negedge clk);
      chk("t1_fall", out_n, 0);
      cap(0, 100, wo, wb, wf);
      e = ones(100); pos = 0;
      add_frame(e, pos, 9'h04C, 8, 0, 1);
      chkw("t1_wave", wo, e);
      chkw("t1_busy", wb, ones(100));
      chk("t1_busy_drop", busy_n, 0);
      chk("t1_idle", out_n, 1);
      repeat (5) @(negedge clk);

      // 8E1, parity bit 1
      d_e = 8'h4C; st_e = 1'b1;
      @(negedge clk); st_e = 1'b0;
      repeat (2) @(negedge clk);
      cap(1, 110, wo, wb, wf);
      e = ones(110); pos = 0;
      add_frame(e, pos, 9'h04C, 8, 2, 1);
      chkw("t2_even_wave", wo, e);
      chkw("t2_even_busy", wb, ones(110));
      chk("t2_even_drop", busy_e, 0);
      repeat (5) @(negedge clk);

      // 8O1, parity bit 0
      d_o = 8'h4C; st_o = 1'b1;
      @(negedge clk); st_o = 1'b0;
      repeat (2) @(negedge clk);
      cap(2, 110, wo, wb, wf);
      e = ones(110); pos = 0;
      add_frame(e, pos, 9'h04C, 8, 1, 1);
      chkw("t2_odd_wave", wo, e);
      chk("t2_odd_parity_bit", wo[95], 0);
      chk("t2_odd_drop", busy_o, 0);
      repeat (5) @(negedge clk);

      // 7N2, 0x55, two stop bits
      d_7 = 7'h55; st_7 = 1'b1;
      @(negedge clk); st_7 = 1'b0;
      repeat (2) @(negedge clk);
      cap(3, 100, wo, wb, wf);
      e = ones(100); pos = 0;
      add_frame(e, pos, 9'h055, 7, 0, 2);
      chkw("t4_7n2_wave", wo, e);
      chkw("t4_7n2_busy", wb, ones(100));
      chk("t4_7n2_drop", busy_7, 0);
      repeat (5) @(negedge clk);

      // six writes on consecutive clocks: A popped at once, B..E fill, F dropped
      for (int i = 0; i < 6; i++) begin
         d_n = words[i]; st_n = 1'b1;
         @(negedge clk);
         if (i == 3) chk("t3_full_before_e", full_n, 0);
         if (i == 4) chk("t3_full_after_e", full_n, 1);
      end
      st_n = 1'b0;
      chk("t3_full_after_f", full_n, 1);
      cap(0, 507, wo, wb, wf);
      e = ones(510); pos = 0;
      for (int i = 0; i < 5; i++) add_frame(e, pos, {1'b0, words[i]}, 8, 0, 1);
      e = e >> 3;
      chkw("t3_wave", wo, e);
      chkw("t3_busy", wb, ones(497));
      chkw("t3_full", wf, ones(96));
      repeat (5) @(negedge clk);

      // reset during data bit 3 with two words queued
      d_n = 8'h00; st_n = 1'b1;
      @(negedge clk); d_n = 8'hFF;
      @(negedge clk); d_n = 8'h0F;
      @(negedge clk); st_n = 1'b0;
      repeat (42) @(negedge clk);
      chk("t5_pre_out", out_n, 0);
      chk("t5_pre_busy", busy_n, 1);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_out", out_n, 1);
      chk("t5_rst_busy", busy_n, 0);
      chk("t5_rst_full", full_n, 0);
      repeat (2) @(negedge clk);
      chk("t5_rst_out_hold", out_n, 1);
      rst_n = 1'b1;
      cap(0, 200, wo, wb, wf);
      chkw("t5_quiet_out", wo, ones(200));
      chkw("t5_quiet_busy", wb, '0);
      chkw("t5_quiet_full", wf, '0);

      // start held 3 clocks: three identical frames, never full
      d_n = 8'h3C; st_n = 1'b1;
      @(negedge clk);
      chk("t6_full1", full_n, 0);
      @(negedge clk);
      chk("t6_full2", full_n, 0);
      @(negedge clk); st_n = 1'b0;
      chk("t6_full3", full_n, 0);
      cap(0, 310, wo, wb, wf);
      e = ones(310); pos = 0;
      for (int i = 0; i < 3; i++) add_frame(e, pos, 9'h03C, 8, 0, 1);
      chkw("t6_wave", wo, e);
      chkw("t6_busy", wb, ones(300));
      chkw("t6_full", wf, '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
